// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering a req/gnt/rvalid core handshake with an optional grant delay.
// Define DMEM_MISALIGN_CHECK_EN to answer addr[1:0]!=0 with an error instead of hitting the enclosing word.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_next;
  logic        w_gnt_fsm;
  logic        w_gnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] mem_data [DEPTH_WORDS];

  logic [31:0]   w_offset;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_misalign;
  logic          w_err;

  // BASE_ADDR is aligned to the memory size, so the upper offset bits being zero means "in range"
  assign w_offset   = data_addr_i - BASE_ADDR;
  assign w_idx      = w_offset[AW+1:2];
  assign w_in_range = (w_offset[31:AW+2] == '0);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = |w_offset[1:0];
`else
  logic w_unused_lsb;
  assign w_misalign   = 1'b0;
  assign w_unused_lsb = ^w_offset[1:0];
`endif

  assign w_err = !w_in_range || w_misalign;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_gnt_fsm    = 1'b0;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        w_state_next = ST_IDLE;
        if (data_req_i) begin
          if (WAIT_CYCLES == 0) begin
            w_gnt_fsm    = 1'b1;
            w_state_next = ST_RESP;
          end else begin
            w_cnt_next   = 3'(WAIT_CYCLES);
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!data_req_i) begin
          w_cnt_next   = 3'd0;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            w_gnt_fsm    = 1'b1;
            w_state_next = ST_RESP;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Grant is combinational, so it must also be forced low while reset is held
  assign w_gnt = w_gnt_fsm && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_gnt) begin
        r_err   <= w_err;
        r_rdata <= (!w_err && !data_we_i) ? mem_data[w_idx] : 32'd0;
      end else begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // Storage has no reset so it can be preloaded and maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_gnt && data_we_i && !w_err) begin
      for (int l = 0; l < 4; l++) begin
        if (data_be_i[l]) begin
          mem_data[w_idx][8*l +: 8] <= data_wdata_i[8*l +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = w_gnt;
  assign data_rvalid_o = (r_state == ST_RESP);
  assign data_rdata_o  = r_rdata;
  assign data_err_o    = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (no wait, 3-cycle wait at a non-zero base) checked against a byte-level memory model.
module tb_data_mem_responder;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        we    [2];
  logic [3:0]  be    [2];
  logic [31:0] wdata [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic        err   [2];
  logic [31:0] rdata [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] mdl [2][256];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req[0]), .data_addr_i(addr[0]), .data_we_i(we[0]), .data_be_i(be[0]),
    .data_wdata_i(wdata[0]), .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]),
    .data_rdata_o(rdata[0]), .data_err_o(err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req[1]), .data_addr_i(addr[1]), .data_we_i(we[1]), .data_be_i(be[1]),
    .data_wdata_i(wdata[1]), .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]),
    .data_rdata_o(rdata[1]), .data_err_o(err[1])
  );

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : BASE1;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Reference: a flat word array indexed by byte offset / 4, updated lane by lane
  function automatic void model(input int d, input logic [31:0] a, input logic w, input logic [3:0] b,
                                input logic [31:0] wd, output logic [31:0] rd, output logic e);
    longint unsigned av = a;
    longint unsigned lo = base_of(d);
    longint unsigned hi = lo + 1024;
    int idx;
    e = (av < lo) || (av >= hi);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (a[1:0] != 2'b00) e = 1'b1;
`endif
    rd = 32'd0;
    if (!e) begin
      idx = int'((av - lo) / 4);
      if (w) begin
        for (int l = 0; l < 4; l++) begin
          if (b[l]) mdl[d][idx][8*l +: 8] = wd[8*l +: 8];
        end
      end else begin
        rd = mdl[d][idx];
      end
    end
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic q_push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the rising edge that follows the grant
  task automatic issue(input int d, input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd);
    int k = 0;
    exp_t e;
    logic [31:0] rd;
    logic er;
    req[d] = 1'b1; addr[d] = a; we[d] = w; be[d] = b; wdata[d] = wd;
    forever begin
      @(negedge clk);
      if (gnt[d] === 1'b1) break;
      k++;
      if (k > 16) begin
        n_checks++;
        n_fail++;
        $display("FAIL gnt_timeout dut%0d: got no grant expected grant after %0d cycles", d, wait_of(d));
        req[d] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("gnt_latency", d, k, wait_of(d));
    model(d, a, w, b, wd, rd, er);
    e.addr = a; e.we = w; e.rdata = rd; e.err = er; e.cyc = cyc;
    q_push(d, e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int n);
    if (n > 0) begin
      req[d] = 1'b0;
      repeat (n) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic abort_req(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd, input int ncyc);
    req[d] = 1'b1; addr[d] = a; we[d] = w; be[d] = 4'hF; wdata[d] = wd;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("abort_no_gnt", d, gnt[d], 1'b0);
      @(posedge clk); #1;
    end
    req[d] = 1'b0;
    @(negedge clk);
    chk("abort_no_gnt_after", d, gnt[d], 1'b0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int unsigned r = $urandom_range(0, 9);
    logic [31:0] b = base_of(d);
    if (r == 0) begin
      if ($urandom_range(0, 1) == 0) return b - 32'd4;
      return b + 32'd1024 + 32'(4 * $urandom_range(0, 63));
    end
    if (r == 1) return b + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(1, 3));
    return b + 32'(4 * $urandom_range(0, 255));
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rvalid[d] === 1'b1) begin
        n_checks++;
        if (q_size(d) == 0) begin
          n_fail++;
          $display("FAIL unexpected_rvalid dut%0d: got rvalid=1 expected no response (cycle %0d)", d, cyc);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          $display("dut%0d rsp addr=%h we=%b rdata=%h err=%b (exp %h/%b)", d, e.addr, e.we, rdata[d], err[d], e.rdata, e.err);
          chk("rsp_rdata", d, rdata[d], e.rdata);
          chk("rsp_err", d, err[d], e.err);
          chk("rsp_latency", d, cyc, e.cyc + 1);
        end
      end else begin
        chk("idle_rvalid", d, rvalid[d], 1'b0);
        chk("idle_rdata", d, rdata[d], 32'd0);
        chk("idle_err", d, err[d], 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected completion within time limit");
    $fatal(1, "time limit reached");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; addr[d] = 32'd0; we[d] = 1'b0; be[d] = 4'h0; wdata[d] = 32'd0;
    end
    // Reset with a request pending: the combinational grant must stay low
    #2 rst_n = 1'b0;
    req[0] = 1'b1;
    #11;
    chk("rst_gnt", 0, gnt[0], 1'b0);
    chk("rst_rvalid", 0, rvalid[0], 1'b0);
    chk("rst_rdata", 0, rdata[0], 32'd0);
    chk("rst_err", 0, err[0], 1'b0);
    chk("rst_gnt", 1, gnt[1], 1'b0);
    chk("rst_rvalid", 1, rvalid[1], 1'b0);
    req[0] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload every word through the port
    for (int i = 0; i < 256; i++) issue(0, 32'(4 * i), 1'b1, 4'hF, (i < 3) ? 32'(i + 1) : $urandom);
    idle(0, 1);
    for (int i = 0; i < 256; i++) issue(1, BASE1 + 32'(4 * i), 1'b1, 4'hF, $urandom);
    idle(1, 1);

    // Full-word write then read, then a single-lane write
    issue(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
    issue(0, 32'h10, 1'b0, 4'hF, 32'd0);
    idle(0, 1);
    issue(0, 32'h10, 1'b1, 4'b0001, 32'h0000_00AA);
    issue(0, 32'h10, 1'b0, 4'b0000, 32'd0);
    idle(0, 2);
    // Write with no lanes enabled is a harmless no-op
    issue(0, 32'h20, 1'b1, 4'b0000, 32'h5555_5555);
    issue(0, 32'h20, 1'b0, 4'hF, 32'd0);
    idle(0, 1);

    // Back-to-back reads, plus a misaligned read
    issue(0, 32'h0, 1'b0, 4'hF, 32'd0);
    issue(0, 32'h4, 1'b0, 4'hF, 32'd0);
    issue(0, 32'h8, 1'b0, 4'hF, 32'd0);
    issue(0, 32'h2, 1'b0, 4'hF, 32'd0);
    idle(0, 1);

    // Out-of-range accesses on both sides, then a full readback for corruption
    issue(0, 32'h400, 1'b0, 4'hF, 32'd0);
    issue(0, 32'h400, 1'b1, 4'hF, 32'hFFFF_FFFF);
    issue(0, 32'hFFFF_FFFC, 1'b1, 4'hF, 32'h1234_5678);
    for (int i = 0; i < 256; i++) issue(0, 32'(4 * i), 1'b0, 4'hF, 32'd0);
    idle(0, 2);

    // Delayed grant: held request, then abandoned requests
    issue(1, BASE1 + 32'h10, 1'b0, 4'hF, 32'd0);
    idle(1, 1);
    abort_req(1, BASE1 + 32'h20, 1'b1, 32'h0BAD_0BAD, 1);
    idle(1, 4);
    abort_req(1, BASE1 + 32'h20, 1'b1, 32'h0BAD_0BAD, 2);
    idle(1, 4);
    issue(1, BASE1 + 32'h20, 1'b0, 4'hF, 32'd0);
    issue(1, 32'h0000_0FFC, 1'b0, 4'hF, 32'd0);
    issue(1, BASE1 + 32'h400, 1'b1, 4'hF, 32'h0);
    idle(1, 2);

    // Reset in the very cycle a delayed write would be granted
    req[1] = 1'b1; addr[1] = BASE1 + 32'h30; we[1] = 1'b1; be[1] = 4'hF; wdata[1] = 32'hA5A5_A5A5;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("gnt_before_rst", 1, gnt[1], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("gnt_in_rst", 1, gnt[1], 1'b0);
    chk("rvalid_in_rst", 1, rvalid[1], 1'b0);
    req[1] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1, BASE1 + 32'h30, 1'b0, 4'hF, 32'd0);
    idle(1, 1);

    // Reset during the response of a granted write: response dropped, write kept
    issue(0, 32'h40, 1'b1, 4'hF, 32'hCAFE_F00D);
    chk("rvalid_before_rst", 0, rvalid[0], 1'b1);
    req[0] = 1'b0;
    rst_n = 1'b0;
    q0.delete();
    #1;
    chk("rvalid_in_rst", 0, rvalid[0], 1'b0);
    chk("rdata_in_rst", 0, rdata[0], 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 32'h40, 1'b0, 4'hF, 32'd0);
    idle(0, 1);

    // Randomized traffic on both responders at once
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          issue(0, rand_addr(0), 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
          idle(0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
        idle(0, 1);
      end
      begin
        for (int n = 0; n < 150; n++) begin
          if ($urandom_range(0, 9) == 0) begin
            idle(1, 1);
            abort_req(1, rand_addr(1), 1'b1, $urandom, int'($urandom_range(1, 2)));
          end
          issue(1, rand_addr(1), 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
          idle(1, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        idle(1, 1);
      end
    join

    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("queue_drained", 0, 32'(q0.size()), 32'd0);
    chk("queue_drained", 1, 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words stored; power of two, 16..4096.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0: grant delay in cycles, 0..7.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
REQ-004 SHALL have these ports; one clock; reset is asynchronous and active-low:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- data_req_i  input  1  core requests an access
- data_addr_i  input  32  byte address
- data_we_i  input  1  1 = write, 0 = read
- data_be_i  input  4  byte enables, bit n = byte lane n
- data_wdata_i  input  32  write data
- data_gnt_o  output  1  request accepted this cycle
- data_rvalid_o  output  1  response valid
- data_rdata_o  output  32  read data, valid with rvalid on reads
- data_err_o  output  1  access error, valid with rvalid

Function
REQ-005 SHALL be a three-state FSM: IDLE, WAIT, RESP.
REQ-006 IDLE: req=1 and WAIT_CYCLES=0 -> gnt=1 combinationally in the same cycle, go to RESP; req=1 and WAIT_CYCLES>0 -> load counter with WAIT_CYCLES, go to WAIT.
REQ-007 WAIT: counter decrements each cycle; gnt=1 in the cycle the counter reads 1, then go to RESP.
REQ-008 The core holds req, addr, we, be and wdata stable until gnt; the block samples them only in the gnt cycle.
REQ-009 If req drops while in WAIT, the block SHALL return to IDLE with no memory access and no rvalid.
REQ-010 RESP: rvalid=1 for exactly one cycle; rdata is the word addressed at grant, all 32 bits regardless of be.
REQ-011 A write in RESP: rvalid=1, rdata=0, and only lanes with be=1 are updated in the gnt cycle.
REQ-012 RESP with req=1 SHALL behave as IDLE for the new request in the same cycle (back-to-back, 1 access/cycle when WAIT_CYCLES=0).
REQ-013 Word index = (addr - BASE_ADDR) >> 2. Addresses outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL still be granted; on rvalid err=1, rdata=0, no write.
REQ-014 be=4'b0000 on a write is a legal no-op: err=0.
REQ-015 gnt, rvalid and err SHALL never be X after reset; rdata is 0 whenever rvalid=0.

Reset
REQ-016 On rst_n=0: state=IDLE, counter=0, gnt=0, rvalid=0, err=0, rdata=0, asynchronously.
REQ-017 Reset mid-access SHALL drop any pending response; a write already granted stays committed; a write not yet granted is never performed.
REQ-018 Memory contents SHALL NOT be reset and SHALL stay loadable by hierarchical $readmemh into the array mem_data.

Configuration
REQ-019 Macro DMEM_MISALIGN_CHECK_EN defined: an access with addr[1:0]!=0 SHALL be granted normally and answered with err=1, rdata=0, and no write.
REQ-020 Macro undefined: addr[1:0] SHALL be ignored, so the access hits the enclosing word with no error.

Verification
REQ-021 WAIT_CYCLES=0: write 0xDEADBEEF to 0x10 with be=1111, then read 0x10 -> gnt same cycle as req, rvalid next cycle, rdata=0xDEADBEEF, err=0.
REQ-022 Word 0x10 holds 0xDEADBEEF: write 0x000000AA with be=0001, then read -> rdata=0xDEADBEAA.
REQ-023 WAIT_CYCLES=3: read with req held -> gnt in the 3rd cycle after req rose, rvalid in the 4th; second run drops req after 1 cycle -> no gnt, no rvalid.
REQ-024 DEPTH_WORDS=256: read 0x400 -> rvalid with err=1, rdata=0; a write to 0x400 leaves words 0..255 unchanged.
REQ-025 Back-to-back reads of 0x0, 0x4, 0x8 on consecutive cycles (preloaded 1, 2, 3) -> three consecutive rvalid cycles with rdata 1, 2, 3; with the macro defined, a read of 0x2 -> err=1.
REQ-026 Assert rst_n=0 in the WAIT state of a write -> gnt and rvalid go 0 immediately and the target word is unchanged after release.
